// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the misalignment rule.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Size code 3 behaves like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (size == SZ_H) mis = off[0];
    else if (size != SZ_B) mis = (off != 2'd0);
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte mask and store-data shift on the way out,
// load-data extract and zero/sign extension on the way back.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [31:0] rdata_sh;

  always_comb begin
    wdata_sh = wdata << {off, 3'b000};
    rdata_sh = rdata >> {off, 3'b000};
    wmask    = 4'hF;
    rdata_ext = rdata_sh;
    // Shifted masks deliberately drop bits that fall past the word boundary.
    case (size)
      SZ_B: begin
        wmask     = 4'b0001 << off;
        rdata_ext = {{24{~is_unsigned & rdata_sh[7]}}, rdata_sh[7:0]};
      end
      SZ_H: begin
        wmask     = 4'b0011 << off;
        rdata_ext = {{16{~is_unsigned & rdata_sh[15]}}, rdata_sh[15:0]};
      end
      default: begin
        wmask     = 4'hF;
        rdata_ext = rdata_sh;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one outstanding request, IDLE -> REQ -> RESP handshake.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned requests with out_err and no memory access.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_valid_q, mem_valid_d;
  logic        mem_wen_q, mem_wen_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_rdata_q, out_rdata_d;
  logic        out_err_q, out_err_d;
  logic [1:0]  req_size_q, req_size_d;
  logic [1:0]  req_off_q, req_off_d;
  logic        req_uns_q, req_uns_d;

  logic [1:0]  a_size, a_off;
  logic        a_uns;
  logic [3:0]  a_wmask;
  logic [31:0] a_wdata_sh, a_rdata_ext;
  logic        trap;

  // The aligner sees the live request while idle and the latched one afterwards.
  assign a_size = (state_q == IDLE) ? in_size        : req_size_q;
  assign a_off  = (state_q == IDLE) ? in_addr[1:0]   : req_off_q;
  assign a_uns  = (state_q == IDLE) ? in_unsigned    : req_uns_q;

  lsu_align u_align (
    .size        (a_size),
    .off         (a_off),
    .is_unsigned (a_uns),
    .wdata       (in_wdata),
    .rdata       (mem_rdata),
    .wmask       (a_wmask),
    .wdata_sh    (a_wdata_sh),
    .rdata_ext   (a_rdata_ext)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(in_size, in_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    mem_valid_d = mem_valid_q;
    mem_wen_d   = mem_wen_q;
    mem_wmask_d = mem_wmask_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    out_valid_d = out_valid_q;
    out_rdata_d = out_rdata_q;
    out_err_d   = out_err_q;
    req_size_d  = req_size_q;
    req_off_d   = req_off_q;
    req_uns_d   = req_uns_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          req_size_d  = in_size;
          req_off_d   = in_addr[1:0];
          req_uns_d   = in_unsigned;
          mem_addr_d  = {in_addr[31:2], 2'b00};
          mem_wdata_d = a_wdata_sh;
          in_ready_d  = 1'b0;
          if (trap) begin
            state_d     = RESP;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_rdata_d = 32'd0;
          end else begin
            state_d     = REQ;
            mem_valid_d = 1'b1;
            mem_wen_d   = in_wen;
            mem_wmask_d = in_wen ? a_wmask : 4'h0;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          mem_wen_d   = 1'b0;
          mem_wmask_d = 4'h0;
          out_valid_d = 1'b1;
          out_err_d   = 1'b0;
          out_rdata_d = mem_wen_q ? 32'd0 : a_rdata_ext;
        end
      end
      RESP: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_rdata_d = 32'd0;
          out_err_d   = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_wmask_q <= 4'h0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      out_valid_q <= 1'b0;
      out_rdata_q <= 32'd0;
      out_err_q   <= 1'b0;
      req_size_q  <= SZ_B;
      req_off_q   <= 2'd0;
      req_uns_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_wen_q   <= mem_wen_d;
      mem_wmask_q <= mem_wmask_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      out_valid_q <= out_valid_d;
      out_rdata_q <= out_rdata_d;
      out_err_q   <= out_err_d;
      req_size_q  <= req_size_d;
      req_off_q   <= req_off_d;
      req_uns_q   <= req_uns_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_valid = mem_valid_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wmask = {4'h0, mem_wmask_q};
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign out_valid = out_valid_q;
  assign out_rdata = out_rdata_q;
  assign out_err   = out_err_q;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1  load/store request valid.
REQ-004 in_ready  out  1  request accepted when in_valid && in_ready.
REQ-005 in_wen  in  1  1 = store, 0 = load.
REQ-006 in_addr  in  32  byte address.
REQ-007 in_wdata  in  32  store data, LSB-justified.
REQ-008 in_size  in  2  0 = byte, 1 = half, 2 = word; 3 SHALL be treated as word.
REQ-009 in_unsigned  in  1  load zero-extend (1) or sign-extend (0).
REQ-010 out_valid  out  1  response valid.
REQ-011 out_ready  in  1  response consumed when out_valid && out_ready.
REQ-012 out_rdata  out  32  extended load data; 0 for stores.
REQ-013 out_err  out  1  misalignment error flag.
REQ-014 mem_valid  out  1  memory request valid.
REQ-015 mem_ready  in  1  memory accepts request; mem_rdata is valid in the same cycle.
REQ-016 mem_wen  out  1  memory write enable.
REQ-017 mem_addr  out  32  word address, in_addr & ~3; drives both the read address and the write address.
REQ-018 mem_wdata  out  32  store data shifted left by 8*in_addr[1:0].
REQ-019 mem_wmask  out  8  byte mask; bits [7:4] are always 0.
REQ-020 mem_rdata  in  32  word read data.

Function
REQ-021 FSM states SHALL be IDLE, REQ and RESP.
REQ-022 IDLE: in_ready=1; on accept, the request is latched and the FSM moves to REQ (or to RESP, per REQ-034).
REQ-023 REQ: mem_valid=1; mem_* outputs are held stable until mem_ready.
REQ-024 REQ, on mem_valid && mem_ready: load data is captured and the FSM moves to RESP.
REQ-025 RESP: out_valid=1; outputs are held stable until out_ready, then the FSM returns to IDLE.
REQ-026 in_ready SHALL be 0 outside IDLE; there is no request overlap.
REQ-027 Minimum latency: accept at cycle N, mem_valid at N+1, out_valid at N+2.
REQ-028 mem_wmask: byte = 1<<off; half = 3<<off; word = 4'hF; off = in_addr[1:0]; result truncated to 4 bits.
REQ-029 Load data = mem_rdata >> 8*off, then zero- or sign-extended from the access size.
REQ-030 Stores SHALL complete with a response where out_rdata = 0.
REQ-031 mem_valid, mem_wen and mem_wmask SHALL be 0 outside REQ; mem_addr and mem_wdata are don't-care.
REQ-032 A request is misaligned if it is a half access with off[0]=1, or a word access with off != 0.

Reset
REQ-033 On rst the FSM SHALL enter IDLE, and in_ready=1, out_valid=0, mem_valid=0, mem_wen=0, mem_wmask=0, out_rdata=0, out_err=0, from the next edge; any request in flight SHALL be abandoned without a response.

Configuration
REQ-034 With LSU_MISALIGN_TRAP_EN defined: a misaligned request SHALL skip REQ (no memory access) and go IDLE -> RESP with out_err=1 and out_rdata=0.
REQ-035 Without LSU_MISALIGN_TRAP_EN: a misaligned request SHALL be issued using the truncated mask and shifted data of REQ-028/029, and out_err SHALL be tied 0.

Structure
REQ-036 Package lsu_pkg SHALL hold the size encodings (SZ_B/SZ_H/SZ_W) and the FSM state enum.
REQ-037 Sub-module lsu_align (combinational) SHALL compute the mask, the store shift and the load extract/extend; lsu_ctrl holds the FSM and registers.

Verification
REQ-038 Load byte signed: addr 0x80000003, mem_rdata 0x80FF1234 -> mem_addr 0x80000000, out_rdata 0xFFFFFF80.
REQ-039 Store half: addr 0x80000002, wdata 0x0000BEEF -> mem_wmask 0x0C, mem_wdata 0xBEEF0000, mem_wen=1, out_rdata 0.
REQ-040 mem_ready held 0 for 3 cycles -> mem_valid and mem_addr remain stable; out_valid appears 1 cycle after mem_ready=1.
REQ-041 out_ready held 0 -> out_valid and out_rdata remain stable, in_ready=0; a new in_valid is not accepted.
REQ-042 Word load at addr 0x80000001 -> with the macro: out_err=1 at N+1 and mem_valid never asserted; without it: mem_wmask logic unused, out_rdata = mem_rdata >> 8.
REQ-043 rst asserted in REQ -> the next cycle is IDLE with mem_valid=0 and no out_valid.
